// File: rtl/character_motion_if.sv
// Bundle between the input decoder, the motion controller and the sprite draw block.
// The decoder drives requests and floor level; the controller returns position and jump state.
interface character_motion_if #(
  parameter int POS_W = 12
);
  logic             left;
  logic             right;
  logic             jump;
  logic             respawn;
  logic [POS_W-1:0] ground_ypos;
  logic [POS_W-1:0] xpos;
  logic [POS_W-1:0] ypos;
  logic             facing_left;
  logic             jumping;
  logic             landed;

  modport master (
    output left, right, jump, respawn, ground_ypos,
    input  xpos, ypos, facing_left, jumping, landed
  );

  modport slave (
    input  left, right, jump, respawn, ground_ypos,
    output xpos, ypos, facing_left, jumping, landed
  );
endinterface

// File: rtl/character_motion_ctl.sv
// Per-character motion controller: tick-divided walking with screen clamps and a
// rise/fall jump FSM that tracks a variable ground level, with respawn.
module character_motion_ctl #(
  parameter int POS_W       = 12,
  parameter int CHAR_W      = 48,
  parameter int CHAR_H      = 64,
  parameter int INIT_XPOS   = 128,
  parameter int INIT_YPOS   = 672,
  parameter int X_MIN       = 0,
  parameter int X_MAX       = 1024,
  parameter int JUMP_HEIGHT = 61,
  parameter int JUMP_TICKS  = 1_400_000,
  parameter int MOVE_TICKS  = 250_000,
  parameter int AIR_CONTROL = 1
) (
  input logic               clk,
  input logic               rst,
  character_motion_if.slave bus
);
  localparam int MW = (MOVE_TICKS > 1) ? $clog2(MOVE_TICKS) : 1;
  localparam int JW = (JUMP_TICKS > 1) ? $clog2(JUMP_TICKS) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RISE = 2'd1;
  localparam logic [1:0] FALL = 2'd2;

  localparam logic [POS_W-1:0] X_LO   = POS_W'(X_MIN);
  localparam logic [POS_W-1:0] X_HI   = POS_W'(X_MAX - CHAR_W);
  localparam logic [POS_W-1:0] INIT_X = POS_W'(INIT_XPOS);
  localparam logic [POS_W-1:0] INIT_Y = POS_W'(INIT_YPOS);
  localparam logic [POS_W-1:0] JH     = POS_W'(JUMP_HEIGHT);

  logic [1:0]       state_reg, state_next;
  logic [POS_W-1:0] xpos_reg, xpos_next;
  logic [POS_W-1:0] ypos_reg, ypos_next;
  logic [POS_W-1:0] apex_reg, apex_next;
  logic             facing_reg, facing_next;
  logic             landed_reg, landed_next;
  logic             jump_q_reg;
  logic [MW-1:0]    move_cnt_reg, move_cnt_next;
  logic [JW-1:0]    jump_cnt_reg, jump_cnt_next;

  logic             move_tick, jump_tick, jump_req;
  logic [POS_W:0]   ypos_inc;

  always_comb begin
    move_tick     = (move_cnt_reg == MW'(MOVE_TICKS - 1));
    jump_tick     = (state_reg != IDLE) && (jump_cnt_reg == JW'(JUMP_TICKS - 1));
    jump_req      = bus.jump & ~jump_q_reg;
    ypos_inc      = {1'b0, ypos_reg} + 1'b1;
    state_next    = state_reg;
    xpos_next     = xpos_reg;
    ypos_next     = ypos_reg;
    apex_next     = apex_reg;
    facing_next   = facing_reg;
    landed_next   = 1'b0;
    move_cnt_next = move_tick ? '0 : move_cnt_reg + 1'b1;

    // Facing follows the request even when the position is pinned at a clamp.
    if (move_tick && (state_reg == IDLE || AIR_CONTROL != 0)) begin
      if (bus.left && !bus.right) begin
        facing_next = 1'b1;
        if (xpos_reg > X_LO) xpos_next = xpos_reg - 1'b1;
      end else if (bus.right && !bus.left) begin
        facing_next = 1'b0;
        if (xpos_reg < X_HI) xpos_next = xpos_reg + 1'b1;
      end
    end

    case (state_reg)
      IDLE: begin
        if (ypos_reg > bus.ground_ypos) begin
          ypos_next = bus.ground_ypos;
        end else if (ypos_reg < bus.ground_ypos) begin
          state_next = FALL;
        end else if (jump_req) begin
          state_next = RISE;
          apex_next  = (ypos_reg < JH) ? '0 : ypos_reg - JH;
        end
      end
      RISE: begin
        // Apex already reached (e.g. standing at y=0) turns around without decrementing.
        if (jump_tick) begin
          if (ypos_reg == apex_reg) begin
            state_next = FALL;
          end else begin
            ypos_next = ypos_reg - 1'b1;
            if (ypos_reg - 1'b1 == apex_reg) state_next = FALL;
          end
        end
      end
      FALL: begin
        if (jump_tick) begin
          if (ypos_inc >= {1'b0, bus.ground_ypos}) begin
            ypos_next   = bus.ground_ypos;
            state_next  = IDLE;
            landed_next = 1'b1;
          end else begin
            ypos_next = ypos_inc[POS_W-1:0];
          end
        end
      end
      default: state_next = IDLE;
    endcase

    if (state_next != state_reg || state_reg == IDLE || jump_tick) jump_cnt_next = '0;
    else                                                          jump_cnt_next = jump_cnt_reg + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      xpos_reg     <= INIT_X;
      ypos_reg     <= INIT_Y;
      apex_reg     <= '0;
      facing_reg   <= 1'b0;
      landed_reg   <= 1'b0;
      jump_q_reg   <= 1'b0;
      move_cnt_reg <= '0;
      jump_cnt_reg <= '0;
    end else if (bus.respawn) begin
      state_reg    <= IDLE;
      xpos_reg     <= INIT_X;
      ypos_reg     <= INIT_Y;
      apex_reg     <= '0;
      facing_reg   <= 1'b0;
      landed_reg   <= 1'b0;
      jump_q_reg   <= 1'b0;
      move_cnt_reg <= '0;
      jump_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      xpos_reg     <= xpos_next;
      ypos_reg     <= ypos_next;
      apex_reg     <= apex_next;
      facing_reg   <= facing_next;
      landed_reg   <= landed_next;
      jump_q_reg   <= bus.jump;
      move_cnt_reg <= move_cnt_next;
      jump_cnt_reg <= jump_cnt_next;
    end
  end

  assign bus.xpos        = xpos_reg;
  assign bus.ypos        = ypos_reg;
  assign bus.facing_left = facing_reg;
  assign bus.jumping     = (state_reg != IDLE);
  assign bus.landed      = landed_reg;
endmodule

// File: tb/tb_character_motion_ctl.sv
// Directed bench: two controllers (air control on / off) driven on negedges, checked after posedges.
module tb_character_motion_ctl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   passed = 0;

  always #5 clk = ~clk;

  character_motion_if #(.POS_W(12)) ifa ();
  character_motion_if #(.POS_W(12)) ifb ();

  character_motion_ctl #(
    .POS_W(12), .CHAR_W(48), .CHAR_H(64), .INIT_XPOS(10), .INIT_YPOS(100),
    .X_MIN(0), .X_MAX(200), .JUMP_HEIGHT(5), .JUMP_TICKS(2), .MOVE_TICKS(4),
    .AIR_CONTROL(1)
  ) dut_a (.clk(clk), .rst(rst), .bus(ifa));

  character_motion_ctl #(
    .POS_W(12), .CHAR_W(48), .CHAR_H(64), .INIT_XPOS(10), .INIT_YPOS(100),
    .X_MIN(0), .X_MAX(200), .JUMP_HEIGHT(5), .JUMP_TICKS(2), .MOVE_TICKS(4),
    .AIR_CONTROL(0)
  ) dut_b (.clk(clk), .rst(rst), .bus(ifb));

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    $display("check %-16s observed %0d expected %0d", tag, obs, exp);
  endtask

  initial begin
    ifa.left = 0; ifa.right = 0; ifa.jump = 0; ifa.respawn = 0; ifa.ground_ypos = 12'd100;
    ifb.left = 0; ifb.right = 0; ifb.jump = 0; ifb.respawn = 0; ifb.ground_ypos = 12'd100;
    step(2);
    check("rst_xpos", ifa.xpos, 10);
    check("rst_ypos", ifa.ypos, 100);
    check("rst_jumping", ifa.jumping, 0);
    check("rst_facing", ifa.facing_left, 0);
    check("rst_landed", ifa.landed, 0);

    // 1: asynchronous reset in the middle of a jump
    rst = 0; ifa.jump = 1;
    step(1); ifa.jump = 0;
    step(7);
    check("mid_ypos", ifa.ypos, 97);
    check("mid_jumping", ifa.jumping, 1);
    rst = 1; #1;
    check("async_xpos", ifa.xpos, 10);
    check("async_ypos", ifa.ypos, 100);
    check("async_jumping", ifa.jumping, 0);

    // 2: walking right, one pixel per 4 clocks
    step(1); rst = 0; ifa.right = 1;
    step(3);  check("walk_3clk", ifa.xpos, 10);
    step(1);  check("walk_4clk", ifa.xpos, 11);
    step(36); check("walk_40clk", ifa.xpos, 20);
    check("walk_facing", ifa.facing_left, 0);
    ifa.left = 1;
    step(8);  check("both_xpos", ifa.xpos, 20);

    // 3: clamps at both screen edges
    ifa.left = 0;
    step(528); check("right_edge", ifa.xpos, 152);
    step(40);  check("right_clamp", ifa.xpos, 152);
    ifa.right = 0; ifa.left = 1;
    step(608); check("left_edge", ifa.xpos, 0);
    step(20);  check("left_clamp", ifa.xpos, 0);
    check("left_facing", ifa.facing_left, 1);

    // 4: full jump with jump held throughout
    ifa.left = 0; ifa.jump = 1;
    step(1);  check("j_start", ifa.jumping, 1);
    check("j_start_y", ifa.ypos, 100);
    step(10); check("j_apex", ifa.ypos, 95);
    check("j_apex_jmp", ifa.jumping, 1);
    step(9);  check("j_fall_y", ifa.ypos, 99);
    check("j_fall_land", ifa.landed, 0);
    step(1);  check("j_land_y", ifa.ypos, 100);
    check("j_land_pulse", ifa.landed, 1);
    check("j_land_jmp", ifa.jumping, 0);
    step(1);  check("j_pulse_end", ifa.landed, 0);
    step(10); check("j_no_retrig", ifa.jumping, 0);
    ifa.jump = 0;

    // 5: floor drops, then rises
    ifa.ground_ypos = 12'd110;
    step(1);  check("drop_fall", ifa.jumping, 1);
    step(19); check("drop_y109", ifa.ypos, 109);
    check("drop_no_land", ifa.landed, 0);
    step(1);  check("drop_y110", ifa.ypos, 110);
    check("drop_landed", ifa.landed, 1);
    ifa.ground_ypos = 12'd90;
    step(1);  check("snap_up", ifa.ypos, 90);
    check("snap_jumping", ifa.jumping, 0);

    // held respawn keeps INIT values
    ifa.respawn = 1;
    step(3);  check("respawn_x", ifa.xpos, 10);
    check("respawn_y", ifa.ypos, 100);
    ifa.respawn = 0; ifa.ground_ypos = 12'd100;

    // 6: no air control on dut_b
    ifb.respawn = 1;
    step(1); ifb.respawn = 0; ifb.right = 1; ifb.jump = 1;
    step(1);  check("b_jump", ifb.jumping, 1);
    step(19); check("b_air_x", ifb.xpos, 10);
    check("b_air_jmp", ifb.jumping, 1);
    step(1);  check("b_landed", ifb.landed, 1);
    check("b_land_x", ifb.xpos, 10);
    step(3);  check("b_walk_x", ifb.xpos, 11);
    ifb.jump = 0;
    step(1); ifb.jump = 1;
    step(1); ifb.jump = 0;
    step(4);  check("b_rise_y", ifb.ypos, 98);
    check("b_rise_x", ifb.xpos, 11);
    check("b_rise_jmp", ifb.jumping, 1);
    ifb.respawn = 1; ifb.right = 0;
    step(1);  check("b_resp_x", ifb.xpos, 10);
    check("b_resp_y", ifb.ypos, 100);
    check("b_resp_jmp", ifb.jumping, 0);
    ifb.respawn = 0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
